// File: rtl/unpack_pk_stream_pkg.sv
// Shared constants, state encoding and coefficient scaling for the pk unpacker.
// Build option: UNPACK_PK_SHIFTL_EN pre-scales every t1 coefficient by 2^D.
package unpack_pk_stream_pkg;

  localparam int K         = 6;
  localparam int N         = 256;
  localparam int SEEDBYTES = 32;
  localparam int T1_BITS   = 10;
  localparam int D         = 13;
  localparam int COEFF_W   = 32;
  localparam int ACC_W     = 18;
  localparam int PK_BYTES  = SEEDBYTES + K * N * T1_BITS / 8;
  localparam int T1_BYTES  = PK_BYTES - SEEDBYTES;

`ifdef UNPACK_PK_SHIFTL_EN
  localparam int T1_SHIFT = D;
`else
  localparam int T1_SHIFT = 0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RHO  = 3'd1,
    ST_T1   = 3'd2,
    ST_DONE = 3'd3
  } state_t;

  function automatic logic [COEFF_W-1:0] scale_t1(input logic [T1_BITS-1:0] t1);
    logic [COEFF_W-1:0] w;
    w = COEFF_W'(t1);
    return w << T1_SHIFT;
  endfunction

endpackage

// File: rtl/unpack_pk_stream_t1_bit_accumulator.sv
// 18-bit LSB-first bit accumulator: byte push, 10-bit pop into a one-deep output register.
module unpack_pk_stream_t1_bit_accumulator
  import unpack_pk_stream_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               active,
  input  logic [7:0]         in_byte,
  input  logic               in_rts,
  output logic               in_rtr,
  output logic [COEFF_W-1:0] coeff,
  output logic               out_rts,
  input  logic               out_rtr
);

  localparam logic [4:0] POP_BITS = 5'(T1_BITS);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_left;
  logic [4:0]       bc;
  logic [4:0]       bc_left;
  logic             pop;
  logic             push;

  // A byte may be taken in the same cycle as a pop, so room is judged on the
  // bits that remain after this cycle's pop; that keeps input at 1 byte/cycle.
  always_comb begin
    pop      = (bc >= POP_BITS) && (!out_rts || out_rtr);
    bc_left  = pop ? (bc - POP_BITS) : bc;
    acc_left = pop ? (acc >> T1_BITS) : acc;
    in_rtr   = active && (bc_left < POP_BITS);
    push     = in_rts && in_rtr;
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      acc     <= '0;
      bc      <= '0;
      coeff   <= '0;
      out_rts <= 1'b0;
    end else begin
      if (push) begin
        acc <= acc_left | (ACC_W'(in_byte) << bc_left);
        bc  <= bc_left + 5'd8;
      end else begin
        acc <= acc_left;
        bc  <= bc_left;
      end
      if (pop) begin
        coeff   <= scale_t1(acc[T1_BITS-1:0]);
        out_rts <= 1'b1;
      end else if (out_rtr) begin
        out_rts <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/unpack_pk_stream.sv
// Byte-serial Dilithium pk unpacker: captures rho, streams K*N 10-bit t1 coefficients.
// Build option: UNPACK_PK_SHIFTL_EN emits t1<<D instead of raw t1.
//
// state   | meaning
// IDLE    | waiting for start, no bytes accepted
// RHO     | capturing the 32 rho bytes into linear_rho
// T1      | unpacking t1 bytes into the coefficient stream
// DONE    | last coefficient transferred, waiting for start
module unpack_pk_stream
  import unpack_pk_stream_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         in_byte,
  input  logic               in_rts,
  output logic               in_rtr,
  output logic [255:0]       linear_rho,
  output logic               rho_valid,
  output logic [COEFF_W-1:0] coeff,
  output logic [2:0]         coeff_poly,
  output logic [7:0]         coeff_idx,
  output logic               out_rts,
  input  logic               out_rtr,
  output logic               done
);

  state_t      state;
  logic [10:0] byte_cnt;
  logic        restart;
  logic        t1_active;
  logic        acc_rtr;
  logic        in_fire;
  logic        out_fire;
  logic        last_coeff;

  assign restart    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign t1_active  = (state == ST_T1) && (byte_cnt < 11'(T1_BYTES));
  assign in_rtr     = (state == ST_RHO) || acc_rtr;
  assign in_fire    = in_rts && in_rtr;
  assign out_fire   = out_rts && out_rtr;
  assign last_coeff = (coeff_poly == 3'(K - 1)) && (coeff_idx == 8'(N - 1));

  unpack_pk_stream_t1_bit_accumulator u_acc (
    .clock   (clock),
    .reset   (reset),
    .clear   (restart),
    .active  (t1_active),
    .in_byte (in_byte),
    .in_rts  (in_rts),
    .in_rtr  (acc_rtr),
    .coeff   (coeff),
    .out_rts (out_rts),
    .out_rtr (out_rtr)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      linear_rho <= '0;
      rho_valid  <= 1'b0;
      done       <= 1'b0;
      coeff_poly <= '0;
      coeff_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_RHO;
            byte_cnt   <= '0;
            rho_valid  <= 1'b0;
            done       <= 1'b0;
            coeff_poly <= '0;
            coeff_idx  <= '0;
          end
        end
        ST_RHO: begin
          if (in_fire) begin
            linear_rho[{byte_cnt[4:0], 3'b000} +: 8] <= in_byte;
            if (byte_cnt == 11'(SEEDBYTES - 1)) begin
              byte_cnt  <= '0;
              rho_valid <= 1'b1;
              state     <= ST_T1;
            end else begin
              byte_cnt <= byte_cnt + 11'd1;
            end
          end
        end
        ST_T1: begin
          if (in_fire) byte_cnt <= byte_cnt + 11'd1;
          if (out_fire) begin
            coeff_idx <= coeff_idx + 8'd1;
            if (last_coeff) begin
              coeff_poly <= '0;
              done       <= 1'b1;
              state      <= ST_DONE;
            end else if (coeff_idx == 8'(N - 1)) begin
              coeff_poly <= coeff_poly + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
